// File: rtl/alarm_beep.sv
// Threshold alarm with debounced IDLE/WARN/ALARM level, hysteresis on falling
// edges, and an active-low buzzer: cadenced low tone in WARN, continuous high tone in ALARM.
module alarm_beep #(
  parameter int DATA_W    = 16,
  parameter int CNT_W     = 18,
  parameter int DIV_WARN  = 127226,
  parameter int DIV_ALARM = 63613,
  parameter int CAD_CYC   = 16500000,
  parameter int DEB_N     = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] ad_data,
  input  logic              ad_valid,
  input  logic [DATA_W-1:0] thr_warn,
  input  logic [DATA_W-1:0] thr_alarm,
  input  logic [DATA_W-1:0] hyst,
  input  logic              mute_req,
  output logic              beep,
  output logic [1:0]        level,
  output logic              muted
);

  typedef enum logic [1:0] {
    L_IDLE  = 2'd0,
    L_WARN  = 2'd1,
    L_ALARM = 2'd2
  } level_t;

  localparam logic [CNT_W-1:0] WARN_LAST  = CNT_W'(DIV_WARN - 1);
  localparam logic [CNT_W-1:0] ALARM_LAST = CNT_W'(DIV_ALARM - 1);
  localparam logic [CNT_W-1:0] WARN_HALF  = CNT_W'(DIV_WARN / 2);
  localparam logic [CNT_W-1:0] ALARM_HALF = CNT_W'(DIV_ALARM / 2);
  localparam logic [24:0]      CAD_ON     = 25'(CAD_CYC);
  localparam logic [24:0]      CAD_LAST   = 25'(2 * CAD_CYC - 1);
  localparam logic [3:0]       DEB_CNT    = 4'(DEB_N);

  level_t            level_q, level_d;
  logic [1:0]        pend_q, pend_d;
  logic [3:0]        deb_cnt_q, deb_cnt_d;
  logic [CNT_W-1:0]  tone_q, tone_d;
  logic [24:0]       cad_q, cad_d;
  logic              muted_q, muted_d;
  logic              beep_q, beep_d;

  logic [DATA_W-1:0] warn_fall, alarm_fall;
  logic [1:0]        up, target;
  logic              level_chg;
  logic [CNT_W-1:0]  tone_last;
  logic              tone_low, gate_on;

  always_comb begin
    warn_fall  = (thr_warn  > hyst) ? (thr_warn  - hyst) : '0;
    alarm_fall = (thr_alarm > hyst) ? (thr_alarm - hyst) : '0;
    if (ad_data > thr_alarm)     up = 2'd2;
    else if (ad_data > thr_warn) up = 2'd1;
    else                         up = 2'd0;
  end

  always_comb begin
    target = level_q;
    if (up > level_q) begin
      target = up;
    end else if (level_q == L_ALARM && ad_data <= alarm_fall) begin
      target = (ad_data <= warn_fall) ? 2'd0 : 2'd1;
    end else if (level_q == L_WARN && ad_data <= warn_fall) begin
      target = 2'd0;
    end
  end

  // ad_valid is a one-cycle strobe with no back-pressure: every strobe is consumed.
  always_comb begin
    pend_d    = pend_q;
    deb_cnt_d = deb_cnt_q;
    level_d   = level_q;
    if (ad_valid) begin
      if (target == level_q) begin
        deb_cnt_d = '0;
      end else if (target == pend_q) begin
        deb_cnt_d = deb_cnt_q + 4'd1;
      end else begin
        pend_d    = target;
        deb_cnt_d = 4'd1;
      end
      if (target != level_q && deb_cnt_d == DEB_CNT) begin
        level_d   = level_t'(pend_d);
        deb_cnt_d = '0;
      end
    end
  end

  always_comb begin
    level_chg = (level_d != level_q);
    tone_last = (level_q == L_ALARM) ? ALARM_LAST : WARN_LAST;
    tone_d    = '0;
    cad_d     = '0;
    if (!level_chg && level_q != L_IDLE) begin
      tone_d = (tone_q == tone_last) ? '0 : tone_q + 1'b1;
      cad_d  = (cad_q == CAD_LAST) ? '0 : cad_q + 25'd1;
    end
  end

  // A rise wins over a simultaneous mute request.
  always_comb begin
    muted_d = muted_q;
    if (level_d == L_IDLE || level_d > level_q) begin
      muted_d = 1'b0;
    end else if (mute_req && level_q != L_IDLE) begin
      muted_d = 1'b1;
    end
  end

  always_comb begin
    tone_low = (level_q == L_ALARM) ? (tone_q >= ALARM_HALF) : (tone_q >= WARN_HALF);
    gate_on  = (level_q == L_ALARM) || (level_q == L_WARN && cad_q < CAD_ON);
    beep_d   = ~(gate_on && tone_low && !muted_d);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      level_q   <= L_IDLE;
      pend_q    <= 2'd0;
      deb_cnt_q <= '0;
      tone_q    <= '0;
      cad_q     <= '0;
      muted_q   <= 1'b0;
      beep_q    <= 1'b1;
    end else begin
      level_q   <= level_d;
      pend_q    <= pend_d;
      deb_cnt_q <= deb_cnt_d;
      tone_q    <= tone_d;
      cad_q     <= cad_d;
      muted_q   <= muted_d;
      beep_q    <= beep_d;
    end
  end

  assign beep  = beep_q;
  assign level = level_q;
  assign muted = muted_q;

endmodule
